spi_read_word_packer: RTL and testbench
=======================================

SPI_READ_WORD_PACKER -- requirements
Module: spi_read_word_packer

Interface
REQ-001 Parameter COUNT_W, default 16, width of byte_count.
REQ-002 system_clk  input  1  single clock; all logic on rising edge.
REQ-003 system_reset_n  input  1  asynchronous, active-low reset.
REQ-004 fifo_empty  input  1  read-data FIFO of the flash-read stage is empty.
REQ-005 fifo_rd_en  output  1  pop request to that FIFO.
REQ-006 fifo_dout  input  8  FIFO byte, valid the cycle after fifo_rd_en.
REQ-007 read_finish  input  1  level from the flash-read stage; all bytes of the transfer are written to the FIFO.
REQ-008 out_valid  output  1  output word valid.
REQ-009 out_ready  input  1  downstream accepts the word.
REQ-010 out_data  output  32  packed word, little-endian.
REQ-011 out_keep  output  4  byte-enable mask; bit n covers out_data[8n+7:8n].
REQ-012 out_last  output  1  final beat of the transfer.
REQ-013 byte_count  output  COUNT_W  bytes popped in the current transfer.
REQ-014 done  output  1  one-cycle pulse when a transfer is fully delivered.

Function
REQ-015 States: COLLECT, HOLD, FLUSH, DONE; reset state COLLECT.
REQ-016 COLLECT: fifo_rd_en = !fifo_empty && no read in flight && fewer than 4 bytes held, so at most one pop is outstanding.
REQ-017 Each popped byte is stored at the next lane (lane 0 first) one cycle after the pop, and byte_count increments by 1 in that cycle.
REQ-018 byte_count wraps modulo 2^COUNT_W; no saturation.
REQ-019 4th byte stored -> next state HOLD: out_valid=1, out_keep=4'hF, out_last=0.
REQ-020 HOLD: fifo_rd_en=0; out_data/out_keep are stable until the handshake; out_valid && out_ready -> lanes cleared, back to COLLECT.
REQ-021 A rising edge of read_finish sets finish_pend, which stays set until DONE.
REQ-022 COLLECT with finish_pend, fifo_empty, no read in flight -> FLUSH.
REQ-023 FLUSH: out_valid=1, out_last=1, out_keep = mask of held lanes (4'h1/4'h3/4'h7); unused lanes of out_data are 0.
REQ-024 FLUSH with 0 held bytes: terminator beat, out_keep=4'h0, out_data=0, out_last=1.
REQ-025 FLUSH handshake -> DONE; DONE lasts exactly one cycle with done=1, clears byte_count, finish_pend and lanes, then COLLECT.
REQ-026 A byte landing in the same cycle as the read_finish edge is stored and counted before the flush decision.
REQ-027 The 4th byte arriving with finish_pend set still goes to HOLD with out_last=0; the transfer then ends with a keep=0 terminator beat.
REQ-028 Bytes that become available after FLUSH is entered are not popped until after DONE.
REQ-029 out_valid never deasserts without a handshake, except on reset.

Reset
REQ-030 Asynchronous assertion sets all of the following at once, including mid-transfer: state=COLLECT, fifo_rd_en=0, out_valid=0, out_data=0, out_keep=0, out_last=0, byte_count=0, done=0, finish_pend=0, in-flight flag=0.
REQ-031 After release, the first pop is no earlier than the first rising edge following deassertion.

Structure
REQ-032 The state encoding and the lane-mask constants (4'h0, 4'h1, 4'h3, 4'h7, 4'hF) live in the shared spi-flash package.
REQ-033 The design is a single flat module; no sub-module is needed.

Verification
REQ-034 Case: 8 bytes 8'h00..8'h07 with out_ready=1, then read_finish.
- Words 32'h03020100 and 32'h07060504, keep F, last 0.
- Then a keep=0 last beat, done, byte_count=8 before clear.
REQ-035 Case: 6 bytes 8'hA0..8'hA5, then read_finish.
- Word 32'hA3A2A1A0, keep F.
- Then 32'h0000A5A4, keep 4'h3, last=1, done one cycle after that handshake.
REQ-036 Case: out_ready held 0 for 10 cycles while a full word is in HOLD.
- out_data stable, fifo_rd_en=0 throughout.
- Packing resumes on the cycle after out_ready=1.
REQ-037 Case: read_finish rises in the same cycle the 3rd byte lands.
- Flush beat keep 4'h7, byte_count=3.
REQ-038 Case: system_reset_n pulsed low mid-HOLD.
- All outputs 0 immediately, without waiting for a clock edge.
- A following 4-byte transfer packs from lane 0.
REQ-039 Case: read_finish with the FIFO empty and no bytes read.
- A single keep=0 last beat, done pulse, byte_count=0.

Source files
------------

// File: rtl/spi_read_word_packer_pkg.sv
// Shared spi-flash definitions: packer state encoding and byte-lane keep masks.
package spi_read_word_packer_pkg;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_HOLD    = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_DONE    = 2'd3
   } packer_state_e;

   localparam logic [3:0] KEEP_NONE = 4'h0;
   localparam logic [3:0] KEEP_1    = 4'h1;
   localparam logic [3:0] KEEP_2    = 4'h3;
   localparam logic [3:0] KEEP_3    = 4'h7;
   localparam logic [3:0] KEEP_ALL  = 4'hF;

   // Keep mask for a partially filled word holding 'held' bytes from lane 0 up.
   function automatic logic [3:0] held_keep(input logic [2:0] held);
      logic [3:0] keep;
      case (held)
         3'd0:    keep = KEEP_NONE;
         3'd1:    keep = KEEP_1;
         3'd2:    keep = KEEP_2;
         3'd3:    keep = KEEP_3;
         default: keep = KEEP_ALL;
      endcase
      return keep;
   endfunction

endpackage

// File: rtl/spi_read_word_packer.sv
// Pops read bytes from the flash-read FIFO and packs them little-endian into
// 32-bit beats; a read_finish edge closes the transfer with a last beat and a done pulse.
module spi_read_word_packer
   import spi_read_word_packer_pkg::*;
#(
   parameter int COUNT_W = 16
) (
   input  logic               system_clk,
   input  logic               system_reset_n,
   input  logic               fifo_empty,
   output logic               fifo_rd_en,
   input  logic [7:0]         fifo_dout,
   input  logic               read_finish,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_data,
   output logic [3:0]         out_keep,
   output logic               out_last,
   output logic [COUNT_W-1:0] byte_count,
   output logic               done
);

   packer_state_e      state_q, state_d;
   logic [3:0][7:0]    lanes_q, lanes_d;
   logic [2:0]         held_q, held_d;
   logic               inflight_q, inflight_d;
   logic               finish_pend_q, finish_pend_d;
   logic               finish_prev_q;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               armed_q;

   localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d       = state_q;
      lanes_d       = lanes_q;
      held_d        = held_q;
      inflight_d    = 1'b0;
      finish_pend_d = finish_pend_q | (read_finish & ~finish_prev_q);
      count_d       = count_q;
      fifo_rd_en    = 1'b0;
      out_valid     = 1'b0;
      out_keep      = KEEP_NONE;
      out_last      = 1'b0;
      done          = 1'b0;

      case (state_q)
         ST_COLLECT: begin
            // armed_q keeps the pop request low until the first edge after reset release.
            fifo_rd_en = armed_q && !fifo_empty && !inflight_q && (held_q < 3'd4);
            inflight_d = fifo_rd_en;
            if (inflight_q) begin
               lanes_d[held_q[1:0]] = fifo_dout;
               held_d               = held_q + 3'd1;
               count_d              = count_q + COUNT_ONE;
               if (held_q == 3'd3) begin
                  state_d = ST_HOLD;
               end
            end else if (finish_pend_q && fifo_empty) begin
               state_d = ST_FLUSH;
            end
         end

         ST_HOLD: begin
            out_valid = 1'b1;
            out_keep  = KEEP_ALL;
            if (out_ready) begin
               lanes_d = '0;
               held_d  = 3'd0;
               state_d = ST_COLLECT;
            end
         end

         ST_FLUSH: begin
            out_valid = 1'b1;
            out_last  = 1'b1;
            out_keep  = held_keep(held_q);
            if (out_ready) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            done          = 1'b1;
            count_d       = '0;
            finish_pend_d = 1'b0;
            lanes_d       = '0;
            held_d        = 3'd0;
            state_d       = ST_COLLECT;
         end

         default: state_d = ST_COLLECT;
      endcase
   end

   // NOTE: the lane storage is reset too, because it drives out_data straight to the port.
   always_ff @(posedge system_clk or negedge system_reset_n) begin
      if (!system_reset_n) begin
         state_q       <= ST_COLLECT;
         lanes_q       <= '0;
         held_q        <= 3'd0;
         inflight_q    <= 1'b0;
         finish_pend_q <= 1'b0;
         finish_prev_q <= 1'b0;
         count_q       <= '0;
         armed_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         lanes_q       <= lanes_d;
         held_q        <= held_d;
         inflight_q    <= inflight_d;
         finish_pend_q <= finish_pend_d;
         finish_prev_q <= read_finish;
         count_q       <= count_d;
         armed_q       <= 1'b1;
      end
   end

   assign out_data   = lanes_q;
   assign byte_count = count_q;

endmodule

// File: tb/tb_spi_read_word_packer.sv
// Randomized bench for spi_read_word_packer: a FIFO model feeds bytes, and a
// transfer-level model (bytes chunked into little-endian words) predicts every beat.
module tb_spi_read_word_packer;

   typedef logic [7:0] byte_q_t[$];

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic [15:0] cnt;
   } beat_t;

   logic        system_clk;
   logic        system_reset_n;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [7:0]  fifo_dout;
   logic        read_finish;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_last;
   logic [15:0] byte_count;
   logic        done;

   spi_read_word_packer #(.COUNT_W(16)) dut (
      .system_clk     (system_clk),
      .system_reset_n (system_reset_n),
      .fifo_empty     (fifo_empty),
      .fifo_rd_en     (fifo_rd_en),
      .fifo_dout      (fifo_dout),
      .read_finish    (read_finish),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_keep       (out_keep),
      .out_last       (out_last),
      .byte_count     (byte_count),
      .done           (done)
   );

   initial system_clk = 1'b0;
   always #5 system_clk = ~system_clk;

   int          vectors = 0;
   int          errors  = 0;
   logic [7:0]  fq[$];
   beat_t       exp_q[$];
   int          pop_count = 0;
   int          ready_mode = 0;
   bit          pop_now;
   bit          exp_done, post_done, done_seen, prev_stall;
   logic [15:0] done_cnt;
   logic [31:0] prev_data;
   logic [3:0]  prev_keep;
   logic        prev_last;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // FIFO model: a pop seen mid-cycle presents its byte just after the next rising edge.
   initial begin
      fifo_empty = 1'b1;
      fifo_dout  = 8'h00;
      forever begin
         @(negedge system_clk);
         pop_now = fifo_rd_en && !fifo_empty;
         @(posedge system_clk);
         #1;
         if (pop_now && fq.size() > 0) begin
            fifo_dout = fq.pop_front();
            pop_count++;
         end
         fifo_empty = (fq.size() == 0);
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge system_clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Compare process: every beat handshake, stall stability, and the done pulse.
   initial begin
      forever begin
         @(negedge system_clk);
         if (!system_reset_n) begin
            prev_stall = 1'b0;
            exp_done   = 1'b0;
            post_done  = 1'b0;
         end else begin
            if (exp_done) begin
               check("done_pulse", done, 1'b1);
               check("done_byte_count", byte_count, done_cnt);
               check("done_no_pop", fifo_rd_en, 1'b0);
               exp_done  = 1'b0;
               post_done = 1'b1;
               done_seen = 1'b1;
            end else begin
               check("done_idle", done, 1'b0);
               if (post_done) begin
                  check("count_cleared", byte_count, 16'd0);
                  post_done = 1'b0;
               end
            end
            if (prev_stall) begin
               check("stall_valid", out_valid, 1'b1);
               check("stall_data", out_data, prev_data);
               check("stall_keep", out_keep, prev_keep);
               check("stall_last", out_last, prev_last);
            end
            if (out_valid) begin
               check("no_pop_while_valid", fifo_rd_en, 1'b0);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", out_valid, 1'b0);
               end else begin
                  beat_t e;
                  e = exp_q.pop_front();
                  check("beat_data", out_data, e.data);
                  check("beat_keep", out_keep, e.keep);
                  check("beat_last", out_last, e.last);
                  if (e.last) begin
                     check("flush_byte_count", byte_count, e.cnt);
                     exp_done = 1'b1;
                     done_cnt = e.cnt;
                  end
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_keep  = out_keep;
            prev_last  = out_last;
         end
      end
   end

   // Transfer model: full 4-byte words, then a last beat with the remainder (or keep=0).
   task automatic build_expect(input byte_q_t b);
      beat_t bt;
      int n, rem, base;
      n = b.size();
      for (int i = 0; i + 4 <= n; i += 4) begin
         bt.data = {b[i+3], b[i+2], b[i+1], b[i]};
         bt.keep = 4'hF;
         bt.last = 1'b0;
         bt.cnt  = 16'd0;
         exp_q.push_back(bt);
      end
      rem     = n % 4;
      base    = n - rem;
      bt.data = 32'd0;
      for (int k = 0; k < rem; k++) bt.data = bt.data | (32'(b[base+k]) << (8 * k));
      bt.keep = 4'((1 << rem) - 1);
      bt.last = 1'b1;
      bt.cnt  = 16'(n);
      exp_q.push_back(bt);
   endtask

   task automatic push_all(input byte_q_t b, input int gap_max);
      foreach (b[i]) begin
         repeat ($urandom_range(0, gap_max)) @(posedge system_clk);
         @(posedge system_clk);
         #1;
         fq.push_back(b[i]);
         fifo_empty = 1'b0;
      end
   endtask

   task automatic finish_and_wait();
      bit ok;
      ok = 1'b0;
      @(posedge system_clk);
      #1;
      read_finish = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge system_clk);
         if (done_seen) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         check("done_timeout", 1'b0, 1'b1);
         exp_q.delete();
      end
      read_finish = 1'b0;
      done_seen   = 1'b0;
      repeat (3) @(posedge system_clk);
   endtask

   task automatic wait_valid(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge system_clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check(name, 1'b0, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t b;
      system_reset_n = 1'b0;
      read_finish    = 1'b0;
      done_seen      = 1'b0;
      ready_mode     = 0;

      #23;
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, 32'd0);
      check("rst_keep", out_keep, 4'h0);
      check("rst_last", out_last, 1'b0);
      check("rst_rd_en", fifo_rd_en, 1'b0);
      check("rst_count", byte_count, 16'd0);
      check("rst_done", done, 1'b0);
      #4 system_reset_n = 1'b1;
      #1 check("release_rd_en", fifo_rd_en, 1'b0);
      repeat (2) @(posedge system_clk);

      // Eight sequential bytes: two full words then a keep=0 terminator.
      b = {};
      for (int i = 0; i < 8; i++) b.push_back(8'(i));
      build_expect(b);
      check("model_w0", exp_q[0].data, 32'h03020100);
      check("model_w1", exp_q[1].data, 32'h07060504);
      check("model_term_keep", exp_q[2].keep, 4'h0);
      check("model_term_cnt", exp_q[2].cnt, 16'd8);
      push_all(b, 0);
      finish_and_wait();

      // Six bytes: one full word then a two-byte last beat.
      b = {};
      for (int i = 0; i < 6; i++) b.push_back(8'hA0 + 8'(i));
      build_expect(b);
      check("model_a_w0", exp_q[0].data, 32'hA3A2A1A0);
      check("model_a_tail", exp_q[1].data, 32'h0000A5A4);
      check("model_a_keep", exp_q[1].keep, 4'h3);
      push_all(b, 1);
      finish_and_wait();

      // Downstream stalls a full word for ten cycles.
      ready_mode = 2;
      b = {};
      for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
      build_expect(b);
      push_all(b, 0);
      wait_valid("hold_timeout");
      for (int i = 0; i < 10; i++) begin
         check("hold_data", out_data, exp_q[0].data);
         check("hold_no_pop", fifo_rd_en, 1'b0);
         if (i < 9) @(negedge system_clk);
      end
      @(posedge system_clk);
      #2;
      out_ready  = 1'b1;
      ready_mode = 0;
      @(negedge system_clk);
      @(negedge system_clk);
      check("resume_pop", fifo_rd_en, 1'b1);
      finish_and_wait();

      // read_finish rises in the cycle the third byte lands.
      b = {8'h5A, 8'hC3, 8'h96};
      build_expect(b);
      check("model_three_keep", exp_q[0].keep, 4'h7);
      pop_count = 0;
      push_all(b, 0);
      for (int i = 0; i < 200; i++) begin
         @(posedge system_clk);
         #2;
         if (pop_count >= 3) break;
      end
      read_finish = 1'b1;
      finish_and_wait();

      // Asynchronous reset while a word sits in HOLD.
      ready_mode = 2;
      b = {8'h11, 8'h12, 8'h13, 8'h14};
      build_expect(b);
      push_all(b, 0);
      wait_valid("pre_reset_timeout");
      #2 system_reset_n = 1'b0;
      #1;
      check("async_valid", out_valid, 1'b0);
      check("async_data", out_data, 32'd0);
      check("async_keep", out_keep, 4'h0);
      check("async_last", out_last, 1'b0);
      check("async_rd_en", fifo_rd_en, 1'b0);
      check("async_count", byte_count, 16'd0);
      check("async_done", done, 1'b0);
      exp_q.delete();
      fq.delete();
      b = {8'h21, 8'h22, 8'h23, 8'h24};
      build_expect(b);
      foreach (b[i]) fq.push_back(b[i]);
      fifo_empty = 1'b0;
      ready_mode = 0;
      repeat (2) @(posedge system_clk);
      #3 system_reset_n = 1'b1;
      #1 check("first_pop_wait", fifo_rd_en, 1'b0);
      finish_and_wait();

      // Empty transfer: lone terminator beat.
      b = {};
      build_expect(b);
      check("model_empty_keep", exp_q[0].keep, 4'h0);
      check("model_empty_cnt", exp_q[0].cnt, 16'd0);
      finish_and_wait();

      // Random lengths, data, arrival gaps and downstream backpressure.
      ready_mode = 1;
      repeat (25) begin
         int n;
         n = $urandom_range(0, 13);
         b = {};
         for (int i = 0; i < n; i++) b.push_back(8'($urandom));
         build_expect(b);
         push_all(b, 3);
         finish_and_wait();
      end

      check("leftover_beats", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
